// File: rtl/mtm_alu_pkg.sv
// Shared constants and types for the mtm_Alu arbiter: FSM encoding, CTL bytes, op codes.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mtm_alu_pkg;

   // Arbiter FSM encoding
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   // CTL byte values seen on the core interface
   localparam logic [7:0] CTL_IDLE = 8'hFF;
   localparam logic [7:0] CTL_ERR  = 8'h93;
   localparam logic [7:0] CMD_A    = 8'hA5;
   localparam logic [7:0] CMD_B    = 8'hC9;

   // ALU op codes carried in CTL[6:4]
   localparam logic [2:0] OP_AND = 3'b000;
   localparam logic [2:0] OP_OR  = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b100;
   localparam logic [2:0] OP_SUB = 3'b101;

   // One operation as presented to the core
   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [7:0]  ctl;
   } core_op_t;

   // A CTL byte with the top bit set is a command, not an ALU op
   function automatic logic is_cmd(input logic [7:0] ctl);
      return ctl[7];
   endfunction

endpackage

// File: rtl/mtm_alu_rr_picker.sv
// Round-robin priority search: first valid requester at or after ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; grant is only a proposal, the caller decides when it is taken.
module mtm_alu_rr_picker #(
   parameter int N_REQ = 2,
   parameter int PTR_W = 1
) (
   input  logic [N_REQ-1:0] req_valid,
   input  logic [PTR_W-1:0] ptr,
   output logic [N_REQ-1:0] grant,
   output logic [PTR_W-1:0] idx,
   output logic             any
);

   localparam int CW = PTR_W + 1;

   logic [CW-1:0] cand;

   // Walk N_REQ positions from ptr, modulo N_REQ, and take the first valid one
   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      cand  = '0;
      for (int k = 0; k < N_REQ; k++) begin
         cand = {1'b0, ptr} + CW'(k);
         if (cand >= CW'(N_REQ)) begin
            cand = cand - CW'(N_REQ);
         end
         if (!any && req_valid[cand[PTR_W-1:0]]) begin
            any                     = 1'b1;
            idx                     = cand[PTR_W-1:0];
            grant[cand[PTR_W-1:0]]  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mtm_alu_arbiter.sv
// Shares one mtm_Alu core between N_REQ requesters, round-robin, one op in flight.
// Latency: accept in cycle t -> resp_valid from t+2+CORE_LAT; min CORE_LAT+3 cycles per op.
// Backpressure: response held stable until resp_ready; no new grant until then.
// Optional: define MTM_ALU_ARB_STATS_EN for saturating per-requester grant counters.
module mtm_alu_arbiter
   import mtm_alu_pkg::*;
#(
   parameter int N_REQ    = 2,
   parameter int CORE_LAT = 1,
   parameter int CNT_W    = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N_REQ-1:0]       req_valid,
   output logic [N_REQ-1:0]       req_ready,
   input  logic [N_REQ*32-1:0]    req_a,
   input  logic [N_REQ*32-1:0]    req_b,
   input  logic [N_REQ*8-1:0]     req_ctl,
   output logic [N_REQ-1:0]       resp_valid,
   input  logic [N_REQ-1:0]       resp_ready,
   output logic [31:0]            resp_c,
   output logic [7:0]             resp_ctl,
   output logic [31:0]            core_a,
   output logic [31:0]            core_b,
   output logic [7:0]             core_ctl,
   input  logic [31:0]            core_c,
   input  logic [7:0]             core_ctl_out,
   output logic [N_REQ*CNT_W-1:0] stat_grant_cnt
);

   localparam int PTR_W = $clog2(N_REQ);
   localparam int LAT_W = (CORE_LAT < 2) ? 1 : $clog2(CORE_LAT + 1);

   logic [1:0]       state;
   logic [PTR_W-1:0] rr_ptr;
   logic [PTR_W-1:0] gnt_idx;
   logic [PTR_W-1:0] pick_idx;
   logic [PTR_W-1:0] ptr_next;
   logic [N_REQ-1:0] pick_grant;
   logic             pick_any;
   logic             grant_fire;
   logic             gnt_resp_ready;
   logic [LAT_W-1:0] lat_cnt;
   core_op_t         sel_op;

   mtm_alu_rr_picker #(
      .N_REQ (N_REQ),
      .PTR_W (PTR_W)
   ) u_picker (
      .req_valid (req_valid),
      .ptr       (rr_ptr),
      .grant     (pick_grant),
      .idx       (pick_idx),
      .any       (pick_any)
   );

   // Grants happen only from IDLE, so req_ready is zero in WAIT and RESP
   assign grant_fire = (state == ST_IDLE) && pick_any;
   assign req_ready  = grant_fire ? pick_grant : '0;
   assign ptr_next   = (pick_idx == PTR_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;

   // Select the winning requester's operands with constant part-selects
   always_comb begin
      sel_op = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (pick_idx == PTR_W'(i)) begin
            sel_op.a   = req_a[32*i +: 32];
            sel_op.b   = req_b[32*i +: 32];
            sel_op.ctl = req_ctl[8*i +: 8];
         end
      end
   end

   // Response is one-hot on the latched grant index, only while in RESP;
   // resp_ready from any other requester is not looked at
   always_comb begin
      resp_valid     = '0;
      gnt_resp_ready = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (gnt_idx == PTR_W'(i)) begin
            resp_valid[i]  = (state == ST_RESP);
            gnt_resp_ready = resp_ready[i];
         end
      end
   end

   // Main FSM: issue to core, count down the core latency, hold the response.
   // Core inputs keep the last issued op between grants so core flags survive.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         rr_ptr   <= '0;
         gnt_idx  <= '0;
         lat_cnt  <= '0;
         core_a   <= '0;
         core_b   <= '0;
         core_ctl <= CTL_IDLE;
         resp_c   <= '0;
         resp_ctl <= CTL_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               if (pick_any) begin
                  core_a   <= sel_op.a;
                  core_b   <= sel_op.b;
                  core_ctl <= sel_op.ctl;
                  gnt_idx  <= pick_idx;
                  rr_ptr   <= ptr_next;
                  lat_cnt  <= LAT_W'(CORE_LAT);
                  state    <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (lat_cnt == '0) begin
                  resp_c   <= core_c;
                  resp_ctl <= core_ctl_out;
                  state    <= ST_RESP;
               end else begin
                  lat_cnt <= lat_cnt - 1'b1;
               end
            end
            ST_RESP: begin
               if (gnt_resp_ready) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

`ifdef MTM_ALU_ARB_STATS_EN
   logic [N_REQ*CNT_W-1:0] grant_cnt;

   // Saturating per-requester grant counters, cleared only by reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant_cnt <= '0;
      end else begin
         for (int i = 0; i < N_REQ; i++) begin
            if (grant_fire && pick_grant[i] &&
                (grant_cnt[i*CNT_W +: CNT_W] != {CNT_W{1'b1}})) begin
               grant_cnt[i*CNT_W +: CNT_W] <= grant_cnt[i*CNT_W +: CNT_W] + 1'b1;
            end
         end
      end
   end

   assign stat_grant_cnt = grant_cnt;
`else
   assign stat_grant_cnt = '0;
`endif

endmodule

// File: tb/tb_mtm_alu_arbiter.sv
// Directed bench for mtm_alu_arbiter with a behavioural 1-cycle ALU core and a response scoreboard.
// Latency: drives N_REQ=2, CORE_LAT=1.
// Backpressure: resp_ready held high except in the stall scenario.
module tb_mtm_alu_arbiter;
   import mtm_alu_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  req_valid, req_ready, resp_valid, resp_ready;
   logic [63:0] req_a, req_b;
   logic [15:0] req_ctl;
   logic [31:0] resp_c, core_a, core_b;
   logic [31:0] core_c = 32'h0;
   logic [7:0]  resp_ctl, core_ctl;
   logic [7:0]  core_ctl_out = 8'hFF;
   logic [31:0] stat_grant_cnt;

   logic        v0 = 1'b0, v1 = 1'b0;
   logic [31:0] a0 = '0, a1 = '0, b0 = '0, b1 = '0;
   logic [7:0]  k0 = '0, k1 = '0;
   assign req_valid = {v1, v0};
   assign req_a     = {a1, a0};
   assign req_b     = {b1, b0};
   assign req_ctl   = {k1, k0};

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [7:0]  ctl;
      logic [31:0] ec;
      logic [7:0]  ectl;
   } vec_t;

   vec_t dq0[$], dq1[$], eq0[$], eq1[$];
   int   order_q[$];
   int   vectors = 0, miscompares = 0;
   int   cyc = 0;
   vec_t mon_e;
   int   mon_o;

`ifdef MTM_ALU_ARB_STATS_EN
   localparam logic [15:0] RR_STAT = 16'd4;
`else
   localparam logic [15:0] RR_STAT = 16'd0;
`endif

   mtm_alu_arbiter #(.N_REQ(2), .CORE_LAT(1), .CNT_W(16)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_a          (req_a),
      .req_b          (req_b),
      .req_ctl        (req_ctl),
      .resp_valid     (resp_valid),
      .resp_ready     (resp_ready),
      .resp_c         (resp_c),
      .resp_ctl       (resp_ctl),
      .core_a         (core_a),
      .core_b         (core_b),
      .core_ctl       (core_ctl),
      .core_c         (core_c),
      .core_ctl_out   (core_ctl_out),
      .stat_grant_cnt (stat_grant_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [2:0] crc3(input logic [35:0] d);
      logic [2:0] r;
      logic       fb;
      r = 3'b000;
      for (int i = 35; i >= 0; i--) begin
         fb = d[i] ^ r[2];
         r  = {r[1:0], 1'b0} ^ (fb ? 3'b011 : 3'b000);
      end
      return r;
   endfunction

   function automatic logic [7:0] ectl(input logic [31:0] c, input logic [3:0] f);
      return {1'b0, f, crc3({c, f})};
   endfunction

   // Behavioural core: flags {carry, overflow, zero, negative}
   function automatic logic [39:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                             input logic [7:0] ctl);
      logic [31:0] c;
      logic        co, v;
      co = 1'b0;
      v  = 1'b0;
      c  = '0;
      if (is_cmd(ctl)) return {32'h0, ctl};
      case (ctl[6:4])
         OP_AND: c = a & b;
         OP_OR:  c = a | b;
         OP_ADD: begin
            {co, c} = {1'b0, a} + {1'b0, b};
            v = (a[31] == b[31]) && (c[31] != a[31]);
         end
         OP_SUB: begin
            {co, c} = {1'b0, a} - {1'b0, b};
            v = (a[31] != b[31]) && (c[31] != a[31]);
         end
         default: return {32'h0, CTL_ERR};
      endcase
      return {c, ectl(c, {co, v, (c == 32'h0), c[31]})};
   endfunction

   always @(posedge clk) {core_c, core_ctl_out} <= alu_model(core_a, core_b, core_ctl);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push(input int i, input logic [31:0] a, input logic [31:0] b,
                       input logic [7:0] ctl, input logic [31:0] ec, input logic [7:0] et);
      vec_t e;
      e.a = a; e.b = b; e.ctl = ctl; e.ec = ec; e.ectl = et;
      if (i == 0) begin dq0.push_back(e); eq0.push_back(e); end
      else        begin dq1.push_back(e); eq1.push_back(e); end
   endtask

   task automatic wait_idle(input string name);
      logic done;
      done = 1'b0;
      for (int k = 0; k < 300 && !done; k++) begin
         @(negedge clk);
         done = (eq0.size() == 0) && (eq1.size() == 0) && (order_q.size() == 0) &&
                (resp_valid == 2'b00) && (v0 == 1'b0) && (v1 == 1'b0);
      end
      if (!done) begin
         vectors++;
         miscompares++;
         $display("FAIL %s_timeout: responses still pending after 300 cycles", name);
      end
      @(negedge clk);
   endtask

   task automatic wait_ready0(input string name);
      logic seen;
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clk);
         seen = req_ready[0];
      end
      if (!seen) begin
         vectors++;
         miscompares++;
         $display("FAIL %s_timeout: req_ready[0] never high", name);
      end
   endtask

   // Requester 0 driver: present queue head, pop once accepted
   initial begin : drv0
      logic acc;
      forever begin
         @(negedge clk);
         acc = rst_n && v0 && req_ready[0];
         @(posedge clk);
         #1;
         if (acc && dq0.size() > 0) void'(dq0.pop_front());
         if (dq0.size() > 0) begin
            v0 = 1'b1; a0 = dq0[0].a; b0 = dq0[0].b; k0 = dq0[0].ctl;
         end else v0 = 1'b0;
      end
   end

   // Requester 1 driver
   initial begin : drv1
      logic acc;
      forever begin
         @(negedge clk);
         acc = rst_n && v1 && req_ready[1];
         @(posedge clk);
         #1;
         if (acc && dq1.size() > 0) void'(dq1.pop_front());
         if (dq1.size() > 0) begin
            v1 = 1'b1; a1 = dq1[0].a; b1 = dq1[0].b; k1 = dq1[0].ctl;
         end else v1 = 1'b0;
      end
   end

   // Monitor: on every response handshake pop and compare
   always @(negedge clk) begin
      if (rst_n && resp_valid != 2'b00) begin
         check("resp_valid_onehot", 32'($countones(resp_valid)), 32'd1);
         for (int i = 0; i < 2; i++) begin
            if (resp_valid[i] && resp_ready[i]) begin
               if (order_q.size() == 0) begin
                  vectors++;
                  miscompares++;
                  $display("FAIL unexpected_response: requester %0d got %h/%h, none expected",
                           i, resp_c, resp_ctl);
               end else begin
                  mon_o = order_q.pop_front();
                  check("grant_order", 32'(i), 32'(mon_o));
                  if (i == 0 && eq0.size() > 0) mon_e = eq0.pop_front();
                  else if (i == 1 && eq1.size() > 0) mon_e = eq1.pop_front();
                  else mon_e.ec = 32'hDEAD_BEEF;
                  check("resp_c", resp_c, mon_e.ec);
                  check("resp_ctl", 32'(resp_ctl), 32'(mon_e.ectl));
               end
            end
         end
      end
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int t0, t1;
      logic seen;
      resp_ready = 2'b11;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_req_ready", 32'(req_ready), 32'h0);
      check("rst_resp_valid", 32'(resp_valid), 32'h0);
      check("rst_resp_c", resp_c, 32'h0);
      check("rst_resp_ctl", 32'(resp_ctl), 32'hFF);
      check("rst_core_a", core_a, 32'h0);
      check("rst_core_b", core_b, 32'h0);
      check("rst_core_ctl", 32'(core_ctl), 32'hFF);
      check("rst_stat", stat_grant_cnt, 32'h0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // ADD 1+2 on requester 0, with latency measurement
      push(0, 32'd1, 32'd2, {1'b0, OP_ADD, 4'h0}, 32'h3, ectl(32'h3, 4'b0000));
      order_q.push_back(0);
      wait_ready0("add_grant");
      t0 = cyc;
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clk);
         seen = resp_valid[0];
      end
      t1 = cyc;
      check("latency", 32'(t1 - t0), 32'd3);
      wait_idle("add");

      // AND on requester 1
      push(1, 32'hF0F0F0F0, 32'h0FF0FF00, {1'b0, OP_AND, 4'h0}, 32'h00F0F000,
           ectl(32'h00F0F000, 4'b0000));
      order_q.push_back(1);
      wait_idle("and");

      // Invalid op -> error byte; command byte -> echoed
      push(0, 32'd7, 32'd9, 8'h20, 32'h0, CTL_ERR);
      order_q.push_back(0);
      wait_idle("err");
      push(1, 32'h0, 32'h0, CMD_A, 32'h0, CMD_A);
      order_q.push_back(1);
      wait_idle("cmd_a");
      check("core_ctl_hold", 32'(core_ctl), 32'(CMD_A));

      // Both requesters busy for two ops each: strict alternation 0,1,0,1
      push(0, 32'd1, 32'd2, {1'b0, OP_OR, 4'h0}, 32'h3, ectl(32'h3, 4'b0000));
      push(1, 32'd5, 32'd3, {1'b0, OP_SUB, 4'h0}, 32'h2, ectl(32'h2, 4'b0000));
      push(0, 32'hFFFFFFFF, 32'd1, {1'b0, OP_ADD, 4'h0}, 32'h0, ectl(32'h0, 4'b1010));
      push(1, 32'h0, 32'd1, {1'b0, OP_SUB, 4'h0}, 32'hFFFFFFFF, ectl(32'hFFFFFFFF, 4'b1001));
      order_q.push_back(0); order_q.push_back(1);
      order_q.push_back(0); order_q.push_back(1);
      wait_idle("rr");
      check("stat_cnt0", 32'(stat_grant_cnt[15:0]), 32'(RR_STAT));
      check("stat_cnt1", 32'(stat_grant_cnt[31:16]), 32'(RR_STAT));

      // Stall the response 5 cycles with requester 1 waiting
      resp_ready = 2'b10;
      push(0, 32'd6, 32'd3, {1'b0, OP_SUB, 4'h0}, 32'h3, ectl(32'h3, 4'b0000));
      push(1, 32'h0, 32'h0, CMD_B, 32'h0, CMD_B);
      order_q.push_back(0); order_q.push_back(1);
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         @(negedge clk);
         seen = resp_valid[0];
      end
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("stall_resp_valid", 32'(resp_valid), 32'h1);
         check("stall_resp_c", resp_c, 32'h3);
         check("stall_resp_ctl", 32'(resp_ctl), 32'(ectl(32'h3, 4'b0000)));
         check("stall_req_ready", 32'(req_ready), 32'h0);
      end
      @(posedge clk);
      #1 resp_ready = 2'b11;
      @(negedge clk);
      @(negedge clk);
      check("grant_after_handshake", 32'(req_ready), 32'h2);
      wait_idle("stall");

      // Reset while the op waits on the core
      push(0, 32'd8, 32'd8, {1'b0, OP_ADD, 4'h0}, 32'd16, ectl(32'd16, 4'b0000));
      order_q.push_back(0);
      wait_ready0("rst_grant");
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_resp_valid", 32'(resp_valid), 32'h0);
      check("mid_rst_resp_c", resp_c, 32'h0);
      check("mid_rst_resp_ctl", 32'(resp_ctl), 32'hFF);
      check("mid_rst_core_a", core_a, 32'h0);
      check("mid_rst_core_ctl", 32'(core_ctl), 32'hFF);
      void'(eq0.pop_back());
      void'(order_q.pop_back());
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("no_resp_after_rst", 32'(resp_valid), 32'h0);
      end
      check("stat_after_rst", stat_grant_cnt, 32'h0);
      push(1, 32'd2, 32'd2, {1'b0, OP_ADD, 4'h0}, 32'd4, ectl(32'd4, 4'b0000));
      push(0, 32'd3, 32'd1, {1'b0, OP_SUB, 4'h0}, 32'd2, ectl(32'd2, 4'b0000));
      order_q.push_back(0); order_q.push_back(1);
      @(negedge clk);
      check("post_rst_grant", 32'(req_ready), 32'h1);
      wait_idle("post_rst");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
